// File: rtl/inorder_mpmp_fifo_if.sv
// inorder_mpmp_fifo_if: dispatch/commit handshake bundle for the in-order multi-push/multi-pop queue
// push_vaild/push_data/push_ready: enqueue lanes; pop_vaild/pop_data/pop_ready: retire lanes
// flush: synchronous squash; count/empty/full: occupancy status
interface inorder_mpmp_fifo_if #(
  parameter int DW = 64,
  parameter int DP = 8,
  parameter int PUSH_N = 2,
  parameter int POP_N = 2
);
  localparam int CW = $clog2(DP + 1);
  logic flush;
  logic [PUSH_N-1:0] push_vaild;
  logic push_ready;
  logic [PUSH_N*DW-1:0] push_data;
  logic [POP_N-1:0] pop_vaild;
  logic [POP_N-1:0] pop_ready;
  logic [POP_N*DW-1:0] pop_data;
  logic [CW-1:0] count;
  logic empty;
  logic full;
  modport master (
    output flush, push_vaild, push_data, pop_ready,
    input push_ready, pop_vaild, pop_data, count, empty, full
  );
  modport slave (
    input flush, push_vaild, push_data, pop_ready,
    output push_ready, pop_vaild, pop_data, count, empty, full
  );
endinterface

// File: rtl/inorder_mpmp_fifo.sv
// inorder_mpmp_fifo: in-order queue accepting up to PUSH_N and retiring up to POP_N entries per cycle
// CLK: clock; RSTn: asynchronous active-low reset
// bus (slave): push/pop lanes, flush, count/empty/full status
module inorder_mpmp_fifo #(
  parameter int DW = 64,
  parameter int DP = 8,
  parameter int PUSH_N = 2,
  parameter int POP_N = 2
) (
  input logic CLK,
  input logic RSTn,
  inorder_mpmp_fifo_if.slave bus
);
  localparam int AW = $clog2(DP);
  localparam int CW = $clog2(DP + 1);
  logic [DW-1:0] mem [DP];
  logic [AW:0] wr_ptr, rd_ptr, n_push, n_pop;
  logic [CW-1:0] count;
  logic push_ready, run_push, run_pop;
  assign count = CW'(wr_ptr - rd_ptr);
  assign push_ready = count <= CW'(DP - PUSH_N);
  assign bus.count = count;
  assign bus.push_ready = push_ready;
  assign bus.empty = count == '0;
  assign bus.full = count == CW'(DP);
  genvar j;
  for (j = 0; j < POP_N; j++) begin : g_pop
    assign bus.pop_vaild[j] = count > CW'(j);
    assign bus.pop_data[j*DW +: DW] = mem[AW'(rd_ptr[AW-1:0] + AW'(j))];
  end
  // only the leading run of ones counts, so a gap stops the lanes above it
  always_comb begin
    n_push = '0;
    run_push = 1'b1;
    for (int i = 0; i < PUSH_N; i++) begin
      run_push = run_push & bus.push_vaild[i];
      n_push = n_push + (AW+1)'(run_push);
    end
    n_push = push_ready ? n_push : '0;
  end
  always_comb begin
    n_pop = '0;
    run_pop = 1'b1;
    for (int i = 0; i < POP_N; i++) begin
      run_pop = run_pop & bus.pop_vaild[i] & bus.pop_ready[i];
      n_pop = n_pop + (AW+1)'(run_pop);
    end
  end
  always_ff @(posedge CLK)
    for (int i = 0; i < PUSH_N; i++)
      if (!bus.flush && (AW+1)'(i) < n_push)
        mem[AW'(wr_ptr[AW-1:0] + AW'(i))] <= bus.push_data[i*DW +: DW];
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (bus.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_push;
      rd_ptr <= rd_ptr + n_pop;
    end
endmodule
